// File: rtl/of_tile_scheduler.sv
// of_tile_scheduler: walks an output feature map in raster tile order.
// For each tile it computes the GLB base address and the clipped
// tile dimensions, issues a one-cycle pixel_valid, and waits for the tile
// writer's burst (wr_en_mon high then low) before moving to the next tile.
//
// Handshake: pixel_valid is a one-cycle issue pulse, raised only while
// tile_ready is high in ISSUE. A burst begins when wr_en_mon is seen high
// after issue (a level already high counts) and ends when it is seen low.
// The tile outputs stay stable from LOAD until the next LOAD.
module of_tile_scheduler #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10,
    parameter int TILE_W = 5
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [DIM_W-1:0]  cfg_fm_width,
    input  logic [DIM_W-1:0]  cfg_fm_height,
    input  logic [TILE_W-1:0] cfg_tile_length,
    input  logic [TILE_W-1:0] cfg_tile_height,
    input  logic              tile_ready,
    input  logic              wr_en_mon,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] of_base_addr,
    output logic [ADDR_W-1:0] of_page_length,
    output logic [TILE_W-1:0] of_tile_length,
    output logic [TILE_W-1:0] of_tile_height,
    output logic              busy,
    output logic              done,
    output logic [15:0]       tile_cnt
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_ISSUE      = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_END   = 3'd4,
        S_NEXT       = 3'd5,
        S_FIN        = 3'd6
    } state_t;

    // Position counters carry one extra bit so x+len and y+height never wrap.
    localparam int CW = DIM_W + 1;

    state_t            state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [TILE_W-1:0] tl_q, tl_d;
    logic [TILE_W-1:0] th_q, th_d;
    logic [CW-1:0]     x_q, x_d;
    logic [CW-1:0]     y_q, y_d;
    logic [15:0]       tile_cnt_q, tile_cnt_d;
    logic              pv_q, pv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] page_q, page_d;
    logic [TILE_W-1:0] len_q, len_d;
    logic [TILE_W-1:0] ht_q, ht_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // busy stays high through the done cycle, so start is only honoured
    // once busy has fallen.
    logic              start_ok;
    logic              cfg_zero;
    logic [CW-1:0]     tl_ext, th_ext;
    logic [CW-1:0]     rem_w, rem_h;
    logic [CW-1:0]     x_adv, x_nxt, y_nxt;
    logic              row_wrap;
    logic              last_tile;
    logic [ADDR_W-1:0] addr_calc;

    assign start_ok = start && !busy_q;
    assign cfg_zero = (cfg_fm_width == '0) || (cfg_fm_height == '0) ||
                      (cfg_tile_length == '0) || (cfg_tile_height == '0);

    assign tl_ext    = CW'(tl_q);
    assign th_ext    = CW'(th_q);
    assign rem_w     = CW'(width_q) - x_q;
    assign rem_h     = CW'(height_q) - y_q;
    assign x_adv     = x_q + tl_ext;
    assign row_wrap  = (x_adv >= CW'(width_q));
    assign x_nxt     = row_wrap ? '0 : x_adv;
    assign y_nxt     = row_wrap ? (y_q + th_ext) : y_q;
    assign last_tile = (y_nxt >= CW'(height_q));
    // Address arithmetic is modulo 2^ADDR_W; wrap past the top is legal.
    assign addr_calc = base_q + ADDR_W'(y_q) * ADDR_W'(width_q) + ADDR_W'(x_q);

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (start_ok) state_d = cfg_zero ? S_FIN : S_LOAD;
            S_LOAD:       state_d = S_ISSUE;
            S_ISSUE:      if (tile_ready) state_d = S_WAIT_START;
            S_WAIT_START: if (wr_en_mon) state_d = S_WAIT_END;
            S_WAIT_END:   if (!wr_en_mon) state_d = S_NEXT;
            S_NEXT:       state_d = last_tile ? S_FIN : S_LOAD;
            S_FIN:        state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs for each state.
    always_comb begin
        base_d     = base_q;
        width_d    = width_q;
        height_d   = height_q;
        tl_d       = tl_q;
        th_d       = th_q;
        x_d        = x_q;
        y_d        = y_q;
        tile_cnt_d = tile_cnt_q;
        addr_d     = addr_q;
        page_d     = page_q;
        len_d      = len_q;
        ht_d       = ht_q;
        pv_d       = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    base_d     = cfg_base_addr;
                    width_d    = cfg_fm_width;
                    height_d   = cfg_fm_height;
                    tl_d       = cfg_tile_length;
                    th_d       = cfg_tile_height;
                    x_d        = '0;
                    y_d        = '0;
                    tile_cnt_d = '0;
                end
            end
            S_LOAD: begin
                addr_d = addr_calc;
                page_d = ADDR_W'(width_q);
                len_d  = (tl_ext <= rem_w) ? tl_q : rem_w[TILE_W-1:0];
                ht_d   = (th_ext <= rem_h) ? th_q : rem_h[TILE_W-1:0];
            end
            S_ISSUE: pv_d = tile_ready;
            S_WAIT_END: begin
                if (!wr_en_mon) tile_cnt_d = tile_cnt_q + 16'd1;
            end
            S_NEXT: begin
                x_d = x_nxt;
                y_d = y_nxt;
            end
            S_FIN: done_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d != S_IDLE) || done_d;
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            width_q    <= '0;
            height_q   <= '0;
            tl_q       <= '0;
            th_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            tile_cnt_q <= '0;
            pv_q       <= 1'b0;
            addr_q     <= '0;
            page_q     <= '0;
            len_q      <= '0;
            ht_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            base_q     <= base_d;
            width_q    <= width_d;
            height_q   <= height_d;
            tl_q       <= tl_d;
            th_q       <= th_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tile_cnt_q <= tile_cnt_d;
            pv_q       <= pv_d;
            addr_q     <= addr_d;
            page_q     <= page_d;
            len_q      <= len_d;
            ht_q       <= ht_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pixel_valid    = pv_q;
    assign of_base_addr   = addr_q;
    assign of_page_length = page_q;
    assign of_tile_length = len_q;
    assign of_tile_height = ht_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign tile_cnt       = tile_cnt_q;

endmodule

// File: tb/tb_of_tile_scheduler.sv
// Testbench for of_tile_scheduler: a tile list model fills an expected queue
// at layer start; a monitor pops and compares on every pixel_valid and
// checks tile_cnt on every done pulse.
module tb_of_tile_scheduler;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 10;
  localparam int TILE_W = 5;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [DIM_W-1:0]  cfg_fm_width = '0;
  logic [DIM_W-1:0]  cfg_fm_height = '0;
  logic [TILE_W-1:0] cfg_tile_length = '0;
  logic [TILE_W-1:0] cfg_tile_height = '0;
  logic              tile_ready = 1'b0;
  logic              wr_en_mon = 1'b0;
  logic              pixel_valid;
  logic [ADDR_W-1:0] of_base_addr;
  logic [ADDR_W-1:0] of_page_length;
  logic [TILE_W-1:0] of_tile_length;
  logic [TILE_W-1:0] of_tile_height;
  logic              busy;
  logic              done;
  logic [15:0]       tile_cnt;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  of_tile_scheduler #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .TILE_W(TILE_W)) dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_fm_width(cfg_fm_width),
    .cfg_fm_height(cfg_fm_height), .cfg_tile_length(cfg_tile_length),
    .cfg_tile_height(cfg_tile_height), .tile_ready(tile_ready),
    .wr_en_mon(wr_en_mon), .pixel_valid(pixel_valid),
    .of_base_addr(of_base_addr), .of_page_length(of_page_length),
    .of_tile_length(of_tile_length), .of_tile_height(of_tile_height),
    .busy(busy), .done(done), .tile_cnt(tile_cnt)
  );

  // ---------------- scoreboard state ----------------
  // entry = {addr[15:0], page[15:0], len[4:0], height[4:0]}
  logic [41:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_tiles = 0;
  int done_cnt = 0;
  int pv_cnt = 0;
  int last_pv_cyc = 0;
  int last_done_cyc = 0;
  int drop_cyc = 0;
  int start_cyc = 0;
  int layer_done0 = 0;
  bit rnd_ready = 1'b0;
  logic prev_pv = 1'b0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {pixel_valid, of_base_addr, of_page_length, of_tile_length,
               of_tile_height, busy, done, tile_cnt}, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!rst_n) begin
      prev_pv = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (pixel_valid) begin
        logic [41:0] e;
        pv_cnt++;
        last_pv_cyc = cyc;
        chk("pv_one_cycle", prev_pv, 0);
        chk("busy_at_issue", busy, 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_tile: got addr 0x%0h with no tile expected", of_base_addr);
        end else begin
          e = exp_q.pop_front();
          chk("tile_addr", of_base_addr, e[41:26]);
          chk("tile_page", of_page_length, e[25:10]);
          chk("tile_len", of_tile_length, e[9:5]);
          chk("tile_ht", of_tile_height, e[4:0]);
        end
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        chk("done_tile_cnt", tile_cnt, exp_tiles);
        chk("done_queue_drained", exp_q.size(), 0);
        chk("busy_during_done", busy, 1);
      end
      if (prev_done) chk("busy_done_fall", {busy, done}, 0);
      prev_pv = pixel_valid;
      prev_done = done;
    end
  end

  // ---------------- tile writer model ----------------
  initial begin
    int gap;
    int blen;
    forever begin
      @(negedge clock);
      if (rst_n && pixel_valid) begin
        gap = $urandom_range(0, 2);
        blen = of_tile_length * of_tile_height;
        repeat (gap) @(negedge clock);
        wr_en_mon = 1'b1;
        repeat (blen) @(negedge clock);
        wr_en_mon = 1'b0;
        drop_cyc = cyc;
      end
    end
  end

  // Random tile_ready pattern for the random layers.
  initial forever begin
    @(negedge clock);
    if (rnd_ready) tile_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  // Reference tile list: raster walk with clipped edges, addresses mod 2^16.
  task automatic begin_layer(input int base, input int w, input int h,
                             input int tl, input int th);
    int n;
    int a;
    int l;
    int t;
    exp_q.delete();
    n = 0;
    if (w != 0 && h != 0 && tl != 0 && th != 0) begin
      for (int y = 0; y < h; y += th) begin
        for (int x = 0; x < w; x += tl) begin
          a = (base + y * w + x) % 65536;
          l = (tl < w - x) ? tl : w - x;
          t = (th < h - y) ? th : h - y;
          exp_q.push_back({16'(a), 16'(w), 5'(l), 5'(t)});
          n++;
        end
      end
    end
    exp_tiles = n;
    layer_done0 = done_cnt;
    @(negedge clock);
    cfg_base_addr = 16'(base);
    cfg_fm_width = 10'(w);
    cfg_fm_height = 10'(h);
    cfg_tile_length = 5'(tl);
    cfg_tile_height = 5'(th);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20000 && done_cnt == layer_done0; i++) @(negedge clock);
    if (done_cnt == layer_done0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no done within budget, tiles left %0d", name, exp_q.size());
    end else begin
      repeat (4) @(negedge clock);
      chk({name, "_done_pulses"}, done_cnt - layer_done0, 1);
    end
  endtask

  task automatic wait_pv(input string name, input int target);
    for (int i = 0; i < 2000 && pv_cnt < target; i++) @(negedge clock);
    if (pv_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: pixel_valid count %0d required %0d", name, pv_cnt, target);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p0;
    int d0;
    int viol_pv;
    int viol_st;
    logic [41:0] e0;

    repeat (3) @(negedge clock);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clock);
    chk_all_zero("idle_after_reset");

    // Aligned map, plus start and burst-end latency.
    tile_ready = 1'b1;
    p0 = pv_cnt;
    begin_layer(16'h0100, 8, 4, 4, 2);
    wait_pv("aligned_first", p0 + 1);
    chk("start_latency", last_pv_cyc - start_cyc, 3);
    wait_pv("aligned_second", p0 + 2);
    // First low cycle is seen in WAIT_END, then NEXT, LOAD, ISSUE.
    chk("burst_end_latency", last_pv_cyc - drop_cyc, 4);
    wait_done("aligned");
    chk("aligned_tile_cnt", tile_cnt, 4);
    chk("aligned_pv_count", pv_cnt - p0, 4);

    // Edge clipping.
    p0 = pv_cnt;
    begin_layer(16'h0200, 10, 3, 4, 2);
    wait_done("edge");
    chk("edge_pv_count", pv_cnt - p0, 6);

    // Zero configuration.
    p0 = pv_cnt;
    begin_layer(16'h0300, 8, 4, 0, 2);
    wait_done("zero");
    chk("zero_done_latency", last_done_cyc - start_cyc, 2);
    chk("zero_pv_count", pv_cnt - p0, 0);
    chk("zero_tile_cnt", tile_cnt, 0);

    // Backpressure in ISSUE.
    tile_ready = 1'b0;
    begin_layer(16'h0400, 8, 2, 8, 2);
    e0 = exp_q[0];
    @(negedge clock);
    viol_pv = 0;
    viol_st = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clock);
      if (pixel_valid) viol_pv++;
      if ({of_base_addr, of_page_length, of_tile_length, of_tile_height} != e0) viol_st++;
    end
    chk("bp_no_pv", viol_pv, 0);
    chk("bp_outputs_stable", viol_st, 0);
    chk("bp_busy", busy, 1);
    tile_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_pv", pixel_valid, 1);
    wait_done("bp");

    // Start while busy and cfg changes mid-layer.
    begin_layer(16'h0500, 12, 4, 4, 2);
    wait_pv("busy_first", pv_cnt + 1);
    cfg_base_addr = 16'h7700;
    cfg_fm_width = 10'd20;
    cfg_fm_height = 10'd9;
    cfg_tile_length = 5'd3;
    cfg_tile_height = 5'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cfg_base_addr = 16'(($urandom_range(0, 65535)));
    wait_done("busy");
    repeat (4) @(negedge clock);
    chk("no_restart_busy", busy, 0);

    // Address wrap.
    begin_layer(16'hFFFC, 8, 2, 8, 1);
    wait_done("wrap");

    // Reset during WAIT_END.
    begin_layer(16'h0600, 8, 4, 4, 2);
    wait_pv("rst_first", pv_cnt + 1);
    for (int i = 0; i < 100 && !wr_en_mon; i++) @(negedge clock);
    chk("rst_writer_active", wr_en_mon, 1);
    repeat (2) @(negedge clock);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset_outputs");
    repeat (3) @(negedge clock);
    exp_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 100 && wr_en_mon; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    chk("rst_no_done", done_cnt - d0, 0);
    chk_all_zero("idle_after_midreset");
    p0 = pv_cnt;
    begin_layer(16'h0600, 8, 4, 4, 2);
    wait_done("after_reset");
    chk("after_reset_pv_count", pv_cnt - p0, 4);

    // Random layers with random tile_ready.
    rnd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      begin_layer($urandom_range(0, 65535), $urandom_range(1, 24), $urandom_range(1, 12),
                  $urandom_range(1, 8), $urandom_range(1, 4));
      wait_done("random");
    end
    rnd_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
